chu_gpi_evt: RTL and testbench

CHU_GPI_EVT -- requirements
Module: chu_gpi_evt

---
 rtl/chu_gpi_pkg.sv | 10 +
 rtl/chu_gpi_deb.sv | 60 ++++++
 rtl/chu_gpi_evt.sv | 83 ++++++++
 tb/tb_chu_gpi_evt.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chu_gpi_pkg.sv
// Shared register map for the GPI event slot.
package chu_gpi_pkg;

    localparam logic [4:0] REG_DATA     = 5'd0;
    localparam logic [4:0] REG_RISE_EN  = 5'd1;
    localparam logic [4:0] REG_FALL_EN  = 5'd2;
    localparam logic [4:0] REG_EVT      = 5'd3;
    localparam logic [4:0] REG_IRQ_MASK = 5'd4;

endpackage

// File: rtl/chu_gpi_deb.sv
// Per-bit 2-flop synchronizer with optional shared-tick debounce filter.
// Filter is built only when CHU_GPI_DEBOUNCE_EN is defined.
import chu_gpi_pkg::*;

module chu_gpi_deb #(
    parameter int W        = 8,
    parameter int DB_TICKS = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    output logic [W-1:0] db
);

    logic [W-1:0] sync1;
    logic [W-1:0] sync2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

`ifdef CHU_GPI_DEBOUNCE_EN
    localparam int CW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;

    logic [CW-1:0] cnt;
    logic          tick;
    logic [W-1:0]  prev;
    logic [W-1:0]  db_q;
    logic [W-1:0]  same;

    assign tick = (cnt == CW'(DB_TICKS - 1));
    assign same = ~(sync2 ^ prev);

    // a bit only moves when two consecutive tick samples agree
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            prev <= '0;
            db_q <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + CW'(1);
            if (tick) begin
                prev <= sync2;
                db_q <= (sync2 & same) | (db_q & ~same);
            end
        end
    end

    assign db = db_q;
`else
    assign db = sync2;
`endif

endmodule

// File: rtl/chu_gpi_evt.sv
// GPI slot with edge-detect sticky events and a masked level interrupt.
// Debounce is enabled by defining CHU_GPI_DEBOUNCE_EN.
import chu_gpi_pkg::*;

module chu_gpi_evt #(
    parameter int W        = 8,
    parameter int DB_TICKS = 50000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [W-1:0] din,
    output logic         irq
);

    logic [W-1:0] db;
    logic [W-1:0] db_d;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] rise_en;
    logic [W-1:0] fall_en;
    logic [W-1:0] evt;
    logic [W-1:0] irq_mask;
    logic [W-1:0] evt_set;
    logic [W-1:0] evt_clr;
    logic [W-1:0] wr_bits;
    logic         wr_en;
    logic         unused;

    chu_gpi_deb #(
        .W        (W),
        .DB_TICKS (DB_TICKS)
    ) u_deb (
        .clk   (clk),
        .reset (reset),
        .din   (din),
        .db    (db)
    );

    assign wr_en   = cs && write;
    assign wr_bits = wr_data[W-1:0];
    assign rise    = db & ~db_d;
    assign fall    = ~db & db_d;
    assign evt_set = (rise & rise_en) | (fall & fall_en);
    assign evt_clr = (wr_en && addr == REG_EVT) ? wr_bits : '0;
    assign irq     = |(evt & irq_mask);
    assign unused  = &{1'b0, read, wr_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_d     <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            evt      <= '0;
            irq_mask <= '0;
        end else begin
            db_d <= db;
            // a fresh edge wins over a simultaneous W1C
            evt  <= (evt & ~evt_clr) | evt_set;
            if (wr_en && addr == REG_RISE_EN)  rise_en  <= wr_bits;
            if (wr_en && addr == REG_FALL_EN)  fall_en  <= wr_bits;
            if (wr_en && addr == REG_IRQ_MASK) irq_mask <= wr_bits;
        end
    end

    always_comb begin
        rd_data = '0;
        case (addr)
            REG_DATA:     rd_data = 32'(db);
            REG_RISE_EN:  rd_data = 32'(rise_en);
            REG_FALL_EN:  rd_data = 32'(fall_en);
            REG_EVT:      rd_data = 32'(evt);
            REG_IRQ_MASK: rd_data = 32'(irq_mask);
            default:      rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_chu_gpi_evt.sv
// Scoreboard bench for chu_gpi_evt (W=8, DB_TICKS=4).
// Latency is exact without CHU_GPI_DEBOUNCE_EN; glitch filtering with it.
import chu_gpi_pkg::*;

module tb_chu_gpi_evt;

    localparam int W        = 8;
    localparam int DB_TICKS = 4;
`ifdef CHU_GPI_DEBOUNCE_EN
    localparam int SETTLE = 2 * DB_TICKS + 8;
`else
    localparam int SETTLE = 6;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         cs;
    logic         read;
    logic         write;
    logic [4:0]   addr;
    logic [31:0]  wr_data;
    logic [31:0]  rd_data;
    logic [W-1:0] din;
    logic         irq;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got;
    logic [31:0] e;

    always #5 clk = ~clk;

    chu_gpi_evt #(
        .W        (W),
        .DB_TICKS (DB_TICKS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .din     (din),
        .irq     (irq)
    );

    task automatic bus_wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic peek(input logic [4:0] a, output logic [31:0] v);
        addr = a; read = 1'b1;
        #1;
        v = rd_data;
        read = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        din   = '1;
        idle(3);
        for (int a = 0; a < 32; a++) begin
            exp_q.push_back(32'h0);
            peek(a[4:0], got);
            e = exp_q.pop_front();
            n_cmp++;
            if (got !== e) begin
                n_err++;
                $display("FAIL reset_rd addr=%0d got=%h exp=%h", a, got, e);
            end
        end
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        n_cmp++;
        if (irq !== e[0]) begin
            n_err++;
            $display("FAIL reset_irq got=%b exp=%b", irq, e[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        bus_wr(REG_RISE_EN, 32'h01);
        exp_q.push_back(32'h01);
        exp_q.push_back(32'hFF);
        idle(SETTLE);
        peek(REG_EVT, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reset_rise_evt got=%h exp=%h", got, e);
        end
        peek(REG_DATA, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL reset_db got=%h exp=%h", got, e);
        end
        bus_wr(REG_EVT, 32'hFF);
        bus_wr(REG_RISE_EN, 32'h00);
    endtask

`ifndef CHU_GPI_DEBOUNCE_EN
    task automatic test_latency;
        din = '0;
        idle(SETTLE);
        bus_wr(REG_RISE_EN, 32'hFF);
        bus_wr(REG_IRQ_MASK, 32'hFF);
        bus_wr(REG_EVT, 32'hFF);
        din = 8'h05;
        exp_q.push_back(32'h00);
        @(negedge clk);
        peek(REG_DATA, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL lat_db_k got=%h exp=%h", got, e);
        end
        exp_q.push_back(32'h05);
        exp_q.push_back(32'h00);
        @(negedge clk);
        peek(REG_DATA, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL lat_db_k1 got=%h exp=%h", got, e);
        end
        peek(REG_EVT, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL lat_evt_k1 got=%h exp=%h", got, e);
        end
        exp_q.push_back(32'h05);
        exp_q.push_back(32'h01);
        @(negedge clk);
        peek(REG_EVT, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL lat_evt_k2 got=%h exp=%h", got, e);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (irq !== e[0]) begin
            n_err++;
            $display("FAIL lat_irq_k2 got=%b exp=%b", irq, e[0]);
        end
        bus_wr(REG_IRQ_MASK, 32'h00);
        bus_wr(REG_RISE_EN, 32'h00);
        bus_wr(REG_EVT, 32'hFF);
    endtask
`else
    task automatic test_glitch;
        logic seen;
        int   hit_at;
        din = '0;
        idle(SETTLE);
        bus_wr(REG_RISE_EN, 32'h01);
        bus_wr(REG_EVT, 32'hFF);
        seen = 1'b0;
        din[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            peek(REG_DATA, got);
            if (got[0]) seen = 1'b1;
        end
        din[0] = 1'b0;
        for (int i = 0; i < 3 * DB_TICKS; i++) begin
            @(negedge clk);
            peek(REG_DATA, got);
            if (got[0]) seen = 1'b1;
        end
        exp_q.push_back(32'h0);
        e = exp_q.pop_front();
        n_cmp++;
        if (seen !== e[0]) begin
            n_err++;
            $display("FAIL glitch_db got=%b exp=%b", seen, e[0]);
        end
        exp_q.push_back(32'h0);
        peek(REG_EVT, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL glitch_evt got=%h exp=%h", got, e);
        end
        hit_at = -1;
        din[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            peek(REG_DATA, got);
            if (got[0] && hit_at < 0) hit_at = i;
        end
        din[0] = 1'b0;
        exp_q.push_back(32'h1);
        e = exp_q.pop_front();
        n_cmp++;
        if ((hit_at >= 0 && hit_at <= 9) !== e[0]) begin
            n_err++;
            $display("FAIL stable_db hit_at=%0d exp=within 10", hit_at);
        end
        exp_q.push_back(32'h01);
        peek(REG_EVT, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL stable_evt got=%h exp=%h", got, e);
        end
        idle(SETTLE);
        bus_wr(REG_RISE_EN, 32'h00);
        bus_wr(REG_EVT, 32'hFF);
    endtask
`endif

    task automatic test_w1c;
        din = '0;
        idle(SETTLE);
        bus_wr(REG_RISE_EN, 32'h0C);
        bus_wr(REG_IRQ_MASK, 32'h08);
        bus_wr(REG_EVT, 32'hFF);
        exp_q.push_back(32'h0C);
        exp_q.push_back(32'h08);
        peek(REG_RISE_EN, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL w1c_rise_en got=%h exp=%h", got, e);
        end
        peek(REG_IRQ_MASK, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL w1c_mask got=%h exp=%h", got, e);
        end
        din = 8'h0C;
        exp_q.push_back(32'h0C);
        idle(SETTLE);
        peek(REG_EVT, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL w1c_pre got=%h exp=%h", got, e);
        end
        bus_wr(REG_EVT, 32'h04);
        exp_q.push_back(32'h08);
        exp_q.push_back(32'h01);
        peek(REG_EVT, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL w1c_evt got=%h exp=%h", got, e);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (irq !== e[0]) begin
            n_err++;
            $display("FAIL w1c_irq got=%b exp=%b", irq, e[0]);
        end
        bus_wr(REG_EVT, 32'h08);
        exp_q.push_back(32'h00);
        e = exp_q.pop_front();
        n_cmp++;
        if (irq !== e[0]) begin
            n_err++;
            $display("FAIL w1c_irq_drop got=%b exp=%b", irq, e[0]);
        end
        bus_wr(REG_RISE_EN, 32'h00);
        bus_wr(REG_IRQ_MASK, 32'h00);
    endtask

    task automatic test_set_over_clear;
        bus_wr(REG_RISE_EN, 32'h02);
        bus_wr(REG_FALL_EN, 32'h02);
        din = 8'h02;
        idle(SETTLE);
        exp_q.push_back(32'h02);
        peek(REG_EVT, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL soc_pre got=%h exp=%h", got, e);
        end
        din = 8'h00;
        @(negedge clk);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; addr = REG_EVT; wr_data = 32'h02;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; wr_data = '0;
        idle(SETTLE);
        exp_q.push_back(32'h02);
        peek(REG_EVT, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL soc_evt got=%h exp=%h", got, e);
        end
        bus_wr(REG_EVT, 32'h02);
        exp_q.push_back(32'h00);
        peek(REG_EVT, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL soc_clear got=%h exp=%h", got, e);
        end
        bus_wr(REG_RISE_EN, 32'h00);
        bus_wr(REG_FALL_EN, 32'h00);
    endtask

    task automatic test_mask;
        bus_wr(REG_FALL_EN, 32'h80);
        bus_wr(REG_IRQ_MASK, 32'h00);
        din = 8'h80;
        idle(SETTLE);
        bus_wr(REG_EVT, 32'hFF);
        exp_q.push_back(32'h80);
        peek(REG_FALL_EN, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL mask_fall_en got=%h exp=%h", got, e);
        end
        din = 8'h00;
        idle(SETTLE);
        exp_q.push_back(32'h80);
        exp_q.push_back(32'h00);
        peek(REG_EVT, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (got !== e) begin
            n_err++;
            $display("FAIL mask_evt got=%h exp=%h", got, e);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (irq !== e[0]) begin
            n_err++;
            $display("FAIL mask_irq_off got=%b exp=%b", irq, e[0]);
        end
        bus_wr(REG_IRQ_MASK, 32'h80);
        exp_q.push_back(32'h01);
        e = exp_q.pop_front();
        n_cmp++;
        if (irq !== e[0]) begin
            n_err++;
            $display("FAIL mask_irq_on got=%b exp=%b", irq, e[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        wr_data = '0;
        din     = '1;
        test_reset();
`ifndef CHU_GPI_DEBOUNCE_EN
        test_latency();
`else
        test_glitch();
`endif
        test_w1c();
        test_set_over_clear();
        test_mask();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
